// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I run/load controller: FSM states, halt causes
// and the EBREAK opcode the controller watches for on the fetch bus.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EBREAK   = 2'd1,
        CAUSE_HALT_REQ = 2'd2,
        CAUSE_WDOG     = 2'd3
    } halt_cause_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/ctrl_loader.sv
// Program loader: counts accepted words, decodes ld_ready and drives a
// registered instruction-memory write port one cycle after each handshake.
module ctrl_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int AW         = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          allow,
    input  logic          restart,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_fire,
    output logic          ld_done,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   load_cnt
);

    localparam logic [AW:0] DEPTH = (AW+1)'(IMEM_DEPTH);

    logic [AW:0] base;
    logic [AW:0] cnt_next;

    // A reload of an already-complete program starts over at address 0.
    assign base     = restart ? '0 : load_cnt;
    assign cnt_next = base + 1'b1;
    assign ld_ready = !reset && allow && (load_cnt < DEPTH);
    assign ld_fire  = ld_valid && ld_ready;
    assign ld_done  = ld_last || (cnt_next == DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            load_cnt   <= '0;
        end else begin
            // The write register ignores clear so an in-flight word still lands.
            imem_we <= ld_fire;
            if (ld_fire) begin
                imem_waddr <= base[AW-1:0];
                imem_wdata <= ld_data;
            end
            if (clear)
                load_cnt <= '0;
            else if (ld_fire)
                load_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/load controller for the single-cycle RV32I core: loads a program while
// holding the core in reset, then sequences run, halt and single-step.
module cpu_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH  = 64,
    parameter int AW          = 6,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    input  logic          start,
    input  logic          step,
    input  logic          halt_req,
    input  logic          abort,
    input  logic [31:0]   instr,
    output logic          core_reset,
    output logic          core_en,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic [2:0]    state_o,
    output logic [1:0]    halt_cause,
    output logic          loaded,
    output logic [AW:0]   load_cnt,
    output logic [31:0]   cycle_cnt
);

    localparam bit          WDOG_ON    = (WDOG_CYCLES != 0);
    localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES - 1);

    run_state_t  state;
    halt_cause_t cause_q;
    logic        is_ebreak;
    logic        wdog_hit;
    logic        ld_fire;
    logic        ld_done;
    logic        load_allow;
    logic        load_restart;

    assign is_ebreak    = (instr == EBREAK);
    assign load_allow   = (state == ST_IDLE) || (state == ST_LOAD);
    assign load_restart = loaded && (state == ST_IDLE);

    // EBREAK is suppressed in the same cycle it is fetched, hence combinational.
    assign core_en  = !reset && ((state == ST_RUN) || (state == ST_STEP)) && !is_ebreak;
    assign wdog_hit = WDOG_ON && core_en && (cycle_cnt >= WDOG_LIMIT);

    assign state_o    = state;
    assign halt_cause = cause_q;

    ctrl_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .AW         (AW)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .clear      (abort),
        .allow      (load_allow),
        .restart    (load_restart),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_fire    (ld_fire),
        .ld_done    (ld_done),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .load_cnt   (load_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            core_reset <= 1'b1;
            cause_q    <= CAUSE_NONE;
            loaded     <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            if (core_en && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + 32'd1;

            if (abort) begin
                state      <= ST_IDLE;
                core_reset <= 1'b1;
                loaded     <= 1'b0;
                cause_q    <= CAUSE_NONE;
            end else begin
                case (state)
                    ST_IDLE, ST_LOAD: begin
                        if (ld_fire) begin
                            cycle_cnt  <= '0;
                            cause_q    <= CAUSE_NONE;
                            core_reset <= 1'b1;
                            loaded     <= ld_done;
                            state      <= ld_done ? ST_IDLE : ST_LOAD;
                        end else if ((state == ST_IDLE) && start && loaded) begin
                            state      <= ST_RUN;
                            core_reset <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (is_ebreak) begin
                            state   <= ST_HALT;
                            cause_q <= CAUSE_EBREAK;
                        end else if (halt_req) begin
                            state   <= ST_HALT;
                            cause_q <= CAUSE_HALT_REQ;
                        end else if (wdog_hit) begin
                            state   <= ST_HALT;
                            cause_q <= CAUSE_WDOG;
                        end
                    end
                    ST_HALT: begin
                        if (start) begin
                            if (is_ebreak) begin
                                cause_q <= CAUSE_EBREAK;
                            end else begin
                                state   <= ST_RUN;
                                cause_q <= CAUSE_NONE;
                            end
                        end else if (step) begin
                            state <= ST_STEP;
                        end
                    end
                    ST_STEP: state <= ST_HALT;
                    default: begin
                        state      <= ST_IDLE;
                        core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: load, run, EBREAK, step, halt_req,
// watchdog and abort scenarios with hand-computed expectations.
module tb_cpu_run_ctrl;

    localparam int IMEM_DEPTH  = 64;
    localparam int AW          = 6;
    localparam int WDOG_CYCLES = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBR = 32'h0010_0073;

    logic          clk;
    logic          reset;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          start;
    logic          step;
    logic          halt_req;
    logic          abort;
    logic [31:0]   instr;
    logic          core_reset;
    logic          core_en;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [2:0]    state_o;
    logic [1:0]    halt_cause;
    logic          loaded;
    logic [AW:0]   load_cnt;
    logic [31:0]   cycle_cnt;

    int n_tests;
    int n_fail;

    cpu_run_ctrl #(
        .IMEM_DEPTH  (IMEM_DEPTH),
        .AW          (AW),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .start      (start),
        .step       (step),
        .halt_req   (halt_req),
        .abort      (abort),
        .instr      (instr),
        .core_reset (core_reset),
        .core_en    (core_en),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .state_o    (state_o),
        .halt_cause (halt_cause),
        .loaded     (loaded),
        .load_cnt   (load_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        start = 1'b0; step = 1'b0; halt_req = 1'b0; abort = 1'b0; instr = NOP;
        tick(); tick();
        n_tests++;
        if ({state_o, core_reset, core_en, ld_ready, halt_cause, loaded} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: st=%0d crst=%0b en=%0b rdy=%0b cause=%0d loaded=%0b, want st=0 crst=1 en=0 rdy=0 cause=0 loaded=0",
                     state_o, core_reset, core_en, ld_ready, halt_cause, loaded);
        end
        n_tests++;
        if ({imem_we, imem_waddr, imem_wdata, load_cnt, cycle_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: we=%0b addr=%0d data=%h cnt=%0d cyc=%0d, want all 0",
                     imem_we, imem_waddr, imem_wdata, load_cnt, cycle_cnt);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %0b want 1", ld_ready);
        end
    endtask

    task automatic test_load3();
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA000_0000 + i;
            ld_last  = (i == 2);
            tick();
            n_tests++;
            if ({imem_we, imem_waddr, imem_wdata, load_cnt} !== {1'b1, 6'(i), 32'hA000_0000 + 32'(i), 7'(i + 1)}) begin
                n_fail++;
                $display("FAIL load3_word%0d: we=%0b addr=%0d data=%h cnt=%0d, want we=1 addr=%0d data=%h cnt=%0d",
                         i, imem_we, imem_waddr, imem_wdata, load_cnt, i, 32'hA000_0000 + 32'(i), i + 1);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        n_tests++;
        if ({state_o, loaded, load_cnt, core_reset} !== {3'd0, 1'b1, 7'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL load3_done: st=%0d loaded=%0b cnt=%0d crst=%0b, want st=0 loaded=1 cnt=3 crst=1",
                     state_o, loaded, load_cnt, core_reset);
        end
        tick();
        n_tests++;
        if (imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL load3_we_pulse: got %0b want 0", imem_we);
        end
    endtask

    task automatic test_full_load();
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hB000_0000 + i;
            ld_last  = 1'b0;
            tick();
            n_tests++;
            if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 6'(i), 32'hB000_0000 + 32'(i)}) begin
                n_fail++;
                $display("FAIL full_word%0d: we=%0b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                         i, imem_we, imem_waddr, imem_wdata, i, 32'hB000_0000 + 32'(i));
            end
            if (i == 0) begin
                n_tests++;
                if ({state_o, loaded} !== {3'd1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL full_restart: st=%0d loaded=%0b, want st=1 loaded=0", state_o, loaded);
                end
            end
        end
        n_tests++;
        if ({state_o, loaded, load_cnt, ld_ready} !== {3'd0, 1'b1, 7'd64, 1'b0}) begin
            n_fail++;
            $display("FAIL full_done: st=%0d loaded=%0b cnt=%0d rdy=%0b, want st=0 loaded=1 cnt=64 rdy=0",
                     state_o, loaded, load_cnt, ld_ready);
        end
        tick(); tick();
        n_tests++;
        if ({imem_we, load_cnt, ld_ready} !== {1'b0, 7'd64, 1'b0}) begin
            n_fail++;
            $display("FAIL full_65th: we=%0b cnt=%0d rdy=%0b, want we=0 cnt=64 rdy=0", imem_we, load_cnt, ld_ready);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_run_ebreak();
        instr = NOP;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({state_o, core_reset, core_en, cycle_cnt} !== {3'd2, 1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL run_entry: st=%0d crst=%0b en=%0b cyc=%0d, want st=2 crst=0 en=1 cyc=0",
                     state_o, core_reset, core_en, cycle_cnt);
        end
        tick(); tick(); tick(); tick(); tick();
        instr = EBR;
        #1;
        n_tests++;
        if ({state_o, core_en, cycle_cnt} !== {3'd2, 1'b0, 32'd5}) begin
            n_fail++;
            $display("FAIL ebreak_cycle: st=%0d en=%0b cyc=%0d, want st=2 en=0 cyc=5", state_o, core_en, cycle_cnt);
        end
        tick();
        n_tests++;
        if ({state_o, halt_cause, core_en, cycle_cnt} !== {3'd4, 2'd1, 1'b0, 32'd5}) begin
            n_fail++;
            $display("FAIL ebreak_halt: st=%0d cause=%0d en=%0b cyc=%0d, want st=4 cause=1 en=0 cyc=5",
                     state_o, halt_cause, core_en, cycle_cnt);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({state_o, halt_cause} !== {3'd4, 2'd1}) begin
            n_fail++;
            $display("FAIL ebreak_resume_blocked: st=%0d cause=%0d, want st=4 cause=1", state_o, halt_cause);
        end
    endtask

    task automatic test_step();
        instr = NOP;
        step  = 1'b1;
        #1;
        n_tests++;
        if (core_en !== 1'b0) begin
            n_fail++;
            $display("FAIL step_halt_en: got %0b want 0", core_en);
        end
        tick();
        step = 1'b0;
        n_tests++;
        if ({state_o, core_en, cycle_cnt} !== {3'd3, 1'b1, 32'd5}) begin
            n_fail++;
            $display("FAIL step_cycle: st=%0d en=%0b cyc=%0d, want st=3 en=1 cyc=5", state_o, core_en, cycle_cnt);
        end
        tick();
        n_tests++;
        if ({state_o, core_en, cycle_cnt, halt_cause} !== {3'd4, 1'b0, 32'd6, 2'd1}) begin
            n_fail++;
            $display("FAIL step_back: st=%0d en=%0b cyc=%0d cause=%0d, want st=4 en=0 cyc=6 cause=1",
                     state_o, core_en, cycle_cnt, halt_cause);
        end
        tick();
        n_tests++;
        if (cycle_cnt !== 32'd6) begin
            n_fail++;
            $display("FAIL step_once: cyc=%0d want 6", cycle_cnt);
        end
    endtask

    task automatic test_halt_priority();
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        n_tests++;
        if ({state_o, halt_cause, core_en} !== {3'd2, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL start_over_step: st=%0d cause=%0d en=%0b, want st=2 cause=0 en=1", state_o, halt_cause, core_en);
        end
        halt_req = 1'b1; instr = EBR;
        tick();
        halt_req = 1'b0; instr = NOP;
        n_tests++;
        if ({state_o, halt_cause, cycle_cnt} !== {3'd4, 2'd1, 32'd6}) begin
            n_fail++;
            $display("FAIL ebreak_over_req: st=%0d cause=%0d cyc=%0d, want st=4 cause=1 cyc=6", state_o, halt_cause, cycle_cnt);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        halt_req = 1'b1;
        #1;
        n_tests++;
        if (core_en !== 1'b1) begin
            n_fail++;
            $display("FAIL req_still_exec: en=%0b want 1", core_en);
        end
        tick();
        halt_req = 1'b0;
        n_tests++;
        if ({state_o, halt_cause, core_en, cycle_cnt} !== {3'd4, 2'd2, 1'b0, 32'd7}) begin
            n_fail++;
            $display("FAIL req_halt: st=%0d cause=%0d en=%0b cyc=%0d, want st=4 cause=2 en=0 cyc=7",
                     state_o, halt_cause, core_en, cycle_cnt);
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({state_o, core_reset, loaded, load_cnt, halt_cause} !== {3'd0, 1'b1, 1'b0, 7'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL abort_run: st=%0d crst=%0b loaded=%0b cnt=%0d cause=%0d, want st=0 crst=1 loaded=0 cnt=0 cause=0",
                     state_o, core_reset, loaded, load_cnt, halt_cause);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({state_o, core_reset} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_start_ignored: st=%0d crst=%0b, want st=0 crst=1", state_o, core_reset);
        end
        ld_valid = 1'b1; ld_last = 1'b0; ld_data = 32'hC000_0000;
        tick();
        ld_data = 32'hC000_0001;
        tick();
        ld_valid = 1'b0;
        n_tests++;
        if ({state_o, load_cnt} !== {3'd1, 7'd2}) begin
            n_fail++;
            $display("FAIL abort_pre_load: st=%0d cnt=%0d, want st=1 cnt=2", state_o, load_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({state_o, core_reset, loaded, load_cnt} !== {3'd0, 1'b1, 1'b0, 7'd0}) begin
            n_fail++;
            $display("FAIL abort_load: st=%0d crst=%0b loaded=%0b cnt=%0d, want st=0 crst=1 loaded=0 cnt=0",
                     state_o, core_reset, loaded, load_cnt);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_load_start_ignored: st=%0d want 0", state_o);
        end
    endtask

    task automatic test_watchdog();
        int run_cycles;
        ld_valid = 1'b1; ld_last = 1'b0; ld_data = NOP;
        tick();
        ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_tests++;
        if ({state_o, loaded, load_cnt, cycle_cnt} !== {3'd0, 1'b1, 7'd2, 32'd0}) begin
            n_fail++;
            $display("FAIL wdog_reload: st=%0d loaded=%0b cnt=%0d cyc=%0d, want st=0 loaded=1 cnt=2 cyc=0",
                     state_o, loaded, load_cnt, cycle_cnt);
        end
        instr = NOP;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_cycles = 0;
        while (state_o == 3'd2 && run_cycles < 40) begin
            run_cycles++;
            tick();
        end
        n_tests++;
        if (run_cycles != 16) begin
            n_fail++;
            $display("FAIL wdog_run_len: got %0d run cycles want 16", run_cycles);
        end
        n_tests++;
        if ({state_o, halt_cause, core_en, cycle_cnt} !== {3'd4, 2'd3, 1'b0, 32'd16}) begin
            n_fail++;
            $display("FAIL wdog_halt: st=%0d cause=%0d en=%0b cyc=%0d, want st=4 cause=3 en=0 cyc=16",
                     state_o, halt_cause, core_en, cycle_cnt);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({state_o, halt_cause} !== {3'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL wdog_resume: st=%0d cause=%0d, want st=2 cause=0", state_o, halt_cause);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_load3();
        test_full_load();
        test_run_ebreak();
        test_step();
        test_halt_priority();
        test_abort();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
